ultrasonido_ctrl: RTL and testbench
===================================

# ultrasonido_ctrl

Measurement sequencer for the HC-SR04-style ultrasonic ranger. It issues the trigger pulse, times the echo with a 2-flop synchronised input, converts the echo width to whole centimetres, and flags timeouts and out-of-range readings. It enforces the sensor's mandatory hold-off between shots, and it serves both single-shot requests (`orden`) and free-running mode (`continuo`) for the game logic.

## Interface
Parameters:
- `TRIG_CYC`, 500: trigger high time in clocks (10 µs @ 50 MHz).
- `CYC_PER_CM`, 2900: clocks per centimetre of range (58 µs @ 50 MHz).
- `MAX_CM`, 400: saturation value of the distance; reaching it ends the measurement.
- `WAIT_CYC`, 1_500_000: maximum clocks from trigger end to echo rise.
- `HOLDOFF_CYC`, 3_000_000: dead time after every measurement.

Ports:
- `CLKOUT2` in 1: system clock, all logic on its rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `orden` in 1: level request for one measurement, sampled only in IDLE.
- `continuo` in 1: when 1, IDLE starts a new measurement with no request.
- `echo` in 1: raw sensor echo, asynchronous to the clock.
- `trigger` out 1: registered sensor trigger.
- `busy` out 1: 1 in every state except IDLE.
- `done` out 1: one-cycle pulse when `distancia`, `timeout` and `fuera_rango` update.
- `distancia` out 9: last result in cm, 0..MAX_CM.
- `timeout` out 1: last measurement saw no echo rise.
- `fuera_rango` out 1: last measurement saturated at MAX_CM.

## Operation
- Echo sync: `echo` passes through two flops to give `echo_s`, with 2 cycles latency on both edges, so pulse width is preserved. Edges are detected on `echo_s` against its previous value.
- States and transitions:
  - IDLE: if `orden|continuo`, go to TRIG on the next edge.
  - TRIG: `trigger`=1 for exactly TRIG_CYC cycles, then WAIT.
  - WAIT: a counter runs from 0.
    - `echo_s` rise: clear the sub-counter and cm counter, go to MEAS.
    - Counter reaches WAIT_CYC-1 with no rise: end the measurement with `timeout`=1 and `distancia`=0, go to HOLD.
  - MEAS: the sub-counter counts 0..CYC_PER_CM-1. On wrap, the cm counter increments.
    - `echo_s` fall: end with `distancia`=cm counter (floor), flags 0.
    - cm counter reaches MAX_CM while `echo_s`=1: end with `distancia`=MAX_CM and `fuera_rango`=1. The remaining echo is ignored.
  - HOLD: HOLDOFF_CYC cycles, then IDLE. Requests during HOLD are ignored, not queued.
- Ending a measurement loads all three results in the same edge and asserts `done` for that one cycle. Results hold until the next `done`.
- An echo rise in TRIG, HOLD or IDLE is ignored.
- An echo already high on entry to WAIT is not a rise. A valid measurement needs a 0→1 transition of `echo_s` inside WAIT.
- Counters are sized by $clog2 of their parameter. The cm counter is 9 bits and never exceeds MAX_CM (MAX_CM ≤ 511).

## Timing
- Reset values: `trigger`=0, `busy`=0, `done`=0, `distancia`=0, `timeout`=0, `fuera_rango`=0, state IDLE, all counters 0.
- Reset mid-measurement drops `trigger` immediately (asynchronously). No `done` is produced.
- Start latency: `orden` high at edge N gives `trigger`=1 and `busy`=1 from edge N+1.
- `trigger` is high for edges N+1..N+TRIG_CYC. WAIT begins at N+TRIG_CYC+1.
- Raw echo rise at edge E is seen as a rise at E+2. Result: an echo high for W clocks gives `distancia`=floor(W/CYC_PER_CM), with ±1 cycle of sync skew allowed only at exact multiples.
- `done` occurs 1 cycle after the `echo_s` fall is detected.
- Minimum request-to-request period: TRIG_CYC + echo phase + HOLDOFF_CYC + 1 (the IDLE cycle).
- Continuous mode: IDLE lasts exactly one cycle between HOLD and TRIG.

## Test plan
Bench uses TRIG_CYC=4, CYC_PER_CM=10, MAX_CM=20, WAIT_CYC=50, HOLDOFF_CYC=8.
- Reset check: `reset` pulsed mid-TRIG → `trigger`=0 asynchronously; all outputs 0; `busy`=0 after release.
- Single shot: `orden`=1 for 1 cycle, echo rises 10 cycles after trigger end and stays high 35 cycles → trigger high exactly 4 cycles, one `done` with `distancia`=3 and both flags 0, `busy` drops 8 cycles after `done`.
- No echo: `orden` with echo held 0 → `done` 50 cycles after WAIT entry with `timeout`=1 and `distancia`=0.
- Overrange: echo held high 300 cycles → `done` after 200 MEAS cycles with `distancia`=20 and `fuera_rango`=1; echo ignored until IDLE.
- Continuous mode: `continuo`=1 and echo 55 cycles wide each shot → repeated `done` with `distancia`=5; exactly one IDLE cycle between HOLD and TRIG; `orden` pulses during HOLD cause no extra shot.
- Stale echo: echo already high entering WAIT and falling inside WAIT, then no new rise → `timeout`=1.

Source files
------------

// File: rtl/ultrasonido_ctrl.sv
// rtl/ultrasonido_ctrl.sv - HC-SR04 ranger sequencer: trigger, echo timing, cm conversion, hold-off
module ultrasonido_ctrl #(
  parameter int TRIG_CYC    = 500,
  parameter int CYC_PER_CM  = 2900,
  parameter int MAX_CM      = 400,
  parameter int WAIT_CYC    = 1_500_000,
  parameter int HOLDOFF_CYC = 3_000_000
) (
  input  logic       CLKOUT2,
  input  logic       reset,
  input  logic       orden,
  input  logic       continuo,
  input  logic       echo,
  output logic       trigger,
  output logic       busy,
  output logic       done,
  output logic [8:0] distancia,
  output logic       timeout,
  output logic       fuera_rango
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_TRIG = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_MEAS = 3'd3;
  localparam logic [2:0] S_HOLD = 3'd4;

  // TRIG, WAIT and HOLD never overlap, so they share one phase counter
  // sized for the longest of the three.
  localparam int MAXC_TW = (WAIT_CYC > TRIG_CYC) ? WAIT_CYC : TRIG_CYC;
  localparam int MAXC    = (HOLDOFF_CYC > MAXC_TW) ? HOLDOFF_CYC : MAXC_TW;
  localparam int CW      = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam int SW      = (CYC_PER_CM > 1) ? $clog2(CYC_PER_CM) : 1;

  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [SW-1:0] sub;
  logic [8:0]    cm;
  logic          echo_m;
  logic          echo_s;
  logic          echo_d;
  logic          echo_rise;
  logic          echo_fall;

  // Two-flop synchroniser for the asynchronous echo plus one delay stage for edge detection
  always_ff @(posedge CLKOUT2 or posedge reset) begin
    if (reset) begin
      echo_m <= 1'b0;
      echo_s <= 1'b0;
      echo_d <= 1'b0;
    end else begin
      echo_m <= echo;
      echo_s <= echo_m;
      echo_d <= echo_s;
    end
  end

  // Edges only count as a transition of echo_s, so an echo already high on entry is not a rise
  assign echo_rise = echo_s & ~echo_d;
  assign echo_fall = ~echo_s & echo_d;
  assign busy      = (state != S_IDLE);

  // Measurement sequencer; results and done are loaded together when a measurement ends
  always_ff @(posedge CLKOUT2 or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      sub         <= '0;
      cm          <= '0;
      trigger     <= 1'b0;
      done        <= 1'b0;
      distancia   <= '0;
      timeout     <= 1'b0;
      fuera_rango <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (orden | continuo) begin
            state   <= S_TRIG;
            trigger <= 1'b1;
            cnt     <= '0;
          end
        end
        S_TRIG: begin
          if (cnt == CW'(TRIG_CYC - 1)) begin
            state   <= S_WAIT;
            trigger <= 1'b0;
            cnt     <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_WAIT: begin
          if (echo_rise) begin
            state <= S_MEAS;
            sub   <= '0;
            cm    <= '0;
          end else if (cnt == CW'(WAIT_CYC - 1)) begin
            state       <= S_HOLD;
            cnt         <= '0;
            done        <= 1'b1;
            distancia   <= '0;
            timeout     <= 1'b1;
            fuera_rango <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_MEAS: begin
          if (echo_fall) begin
            state       <= S_HOLD;
            cnt         <= '0;
            done        <= 1'b1;
            distancia   <= cm;
            timeout     <= 1'b0;
            fuera_rango <= 1'b0;
          end else if (sub == SW'(CYC_PER_CM - 1)) begin
            sub <= '0;
            if (cm == 9'(MAX_CM - 1)) begin
              // Saturated: the rest of the echo pulse is left to expire during HOLD
              state       <= S_HOLD;
              cnt         <= '0;
              done        <= 1'b1;
              distancia   <= 9'(MAX_CM);
              timeout     <= 1'b0;
              fuera_rango <= 1'b1;
            end else begin
              cm <= cm + 9'd1;
            end
          end else begin
            sub <= sub + 1'b1;
          end
        end
        S_HOLD: begin
          if (cnt == CW'(HOLDOFF_CYC - 1)) begin
            state <= S_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state   <= S_IDLE;
          trigger <= 1'b0;
          cnt     <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ultrasonido_ctrl.sv
// tb/tb_ultrasonido_ctrl.sv - scoreboard bench for ultrasonido_ctrl
module tb_ultrasonido_ctrl;

  logic       CLKOUT2 = 1'b0;
  logic       reset;
  logic       orden;
  logic       continuo;
  logic       echo;
  logic       trigger;
  logic       busy;
  logic       done;
  logic [8:0] distancia;
  logic       timeout;
  logic       fuera_rango;

  typedef struct {
    int d;
    int t;
    int f;
  } res_t;

  res_t q[$];
  int   checks   = 0;
  int   failures = 0;

  ultrasonido_ctrl #(
    .TRIG_CYC   (4),
    .CYC_PER_CM (10),
    .MAX_CM     (20),
    .WAIT_CYC   (50),
    .HOLDOFF_CYC(8)
  ) dut (
    .CLKOUT2    (CLKOUT2),
    .reset      (reset),
    .orden      (orden),
    .continuo   (continuo),
    .echo       (echo),
    .trigger    (trigger),
    .busy       (busy),
    .done       (done),
    .distancia  (distancia),
    .timeout    (timeout),
    .fuera_rango(fuera_rango)
  );

  always #5 CLKOUT2 = ~CLKOUT2;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic push(input int d, input int t, input int f);
    res_t r;
    r.d = d;
    r.t = t;
    r.f = f;
    q.push_back(r);
  endtask

  // Scoreboard: every done pulse is matched against the oldest expected result
  always @(negedge CLKOUT2) begin
    if (!reset && done) begin
      if (q.size() == 0) begin
        check("done_extra", int'(done), 0);
      end else begin
        res_t r;
        r = q.pop_front();
        check("distancia", int'(distancia), r.d);
        check("timeout", int'(timeout), r.t);
        check("fuera_rango", int'(fuera_rango), r.f);
      end
    end
  end

  task automatic pulse_orden();
    @(negedge CLKOUT2);
    orden = 1'b1;
    @(negedge CLKOUT2);
    orden = 1'b0;
  endtask

  task automatic wait_trig_rise();
    int k = 0;
    while (!trigger && k < 100) begin
      @(negedge CLKOUT2);
      k++;
    end
    if (k >= 100) check("trig_rise_timeout", int'(trigger), 1);
  endtask

  // Returns number of negedges trigger was seen high
  task automatic wait_trig_fall(output int n);
    n = 0;
    while (trigger && n < 100) begin
      @(negedge CLKOUT2);
      n++;
    end
    if (n >= 100) check("trig_fall_timeout", int'(trigger), 0);
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 500) begin
      @(negedge CLKOUT2);
      n++;
    end
    if (n >= 500) check("done_timeout", int'(done), 1);
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 500) begin
      @(negedge CLKOUT2);
      n++;
    end
    if (n >= 500) check("idle_timeout", int'(busy), 0);
  endtask

  initial begin
    int n;
    int at;
    reset    = 1'b1;
    orden    = 1'b0;
    continuo = 1'b0;
    echo     = 1'b0;
    repeat (3) @(negedge CLKOUT2);
    reset = 1'b0;
    @(negedge CLKOUT2);
    check("rst_trigger", int'(trigger), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_distancia", int'(distancia), 0);
    check("rst_timeout", int'(timeout), 0);
    check("rst_fuera", int'(fuera_rango), 0);

    // Reset in the middle of TRIG drops trigger without a clock edge
    pulse_orden();
    check("trig_started", int'(trigger), 1);
    check("busy_started", int'(busy), 1);
    #2 reset = 1'b1;
    #1;
    check("async_trigger", int'(trigger), 0);
    check("async_busy", int'(busy), 0);
    @(negedge CLKOUT2);
    reset = 1'b0;
    repeat (2) @(negedge CLKOUT2);
    check("post_rst_busy", int'(busy), 0);
    check("post_rst_distancia", int'(distancia), 0);

    // Single shot: echo 35 cycles wide -> 3 cm
    push(3, 0, 0);
    pulse_orden();
    wait_trig_fall(n);
    check("trig_width", n, 4);
    repeat (10) @(negedge CLKOUT2);
    echo = 1'b1;
    repeat (35) @(negedge CLKOUT2);
    echo = 1'b0;
    wait_done(n);
    wait_idle(n);
    check("holdoff_len", n, 8);

    // No echo at all -> timeout 50 cycles after WAIT entry
    push(0, 1, 0);
    pulse_orden();
    wait_trig_fall(n);
    wait_done(n);
    check("timeout_latency", n, 50);
    wait_idle(n);

    // Overrange: echo held 300 cycles, saturates after 200 MEAS cycles
    push(20, 0, 1);
    pulse_orden();
    wait_trig_fall(n);
    echo = 1'b1;
    at = 0;
    for (int i = 1; i <= 300; i++) begin
      @(negedge CLKOUT2);
      if (done) at = i;
    end
    check("overrange_at", at, 203);
    check("overrange_idle", int'(busy), 0);
    echo = 1'b0;
    repeat (5) @(negedge CLKOUT2);

    // Continuous mode: three shots of 55-cycle echo, orden pulses in HOLD
    continuo = 1'b1;
    for (int s = 0; s < 3; s++) begin
      wait_trig_rise();
      wait_trig_fall(n);
      check("cont_trig_width", n, 4);
      push(5, 0, 0);
      repeat (5) @(negedge CLKOUT2);
      echo = 1'b1;
      repeat (55) @(negedge CLKOUT2);
      echo = 1'b0;
      wait_done(n);
      if (s == 2) continuo = 1'b0;
      repeat (2) @(negedge CLKOUT2);
      orden = 1'b1;
      @(negedge CLKOUT2);
      orden = 1'b0;
      wait_idle(n);
      if (s < 2) begin
        n = 0;
        while (!busy && n < 50) begin
          @(negedge CLKOUT2);
          n++;
        end
        check("cont_idle_cycles", n, 1);
      end
    end
    repeat (30) @(negedge CLKOUT2);
    check("no_extra_shot", int'(busy), 0);

    // Stale echo: high before WAIT, falls inside WAIT, never rises again
    push(0, 1, 0);
    pulse_orden();
    echo = 1'b1;
    wait_trig_fall(n);
    repeat (5) @(negedge CLKOUT2);
    echo = 1'b0;
    wait_done(n);
    wait_idle(n);

    repeat (5) @(negedge CLKOUT2);
    check("scoreboard_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
